// File: rtl/gray_hist_stream.sv
// Grey-level histogram engine: counts samples into NUM_BINS level bins per frame and streams
// the finished histogram one bin per valid/ready beat. Define GRAY_HIST_SAT_EN for saturating bins.
module gray_hist_stream #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_BINS = 6,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned BIN_BASE = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_gray_valid,
  input  logic [DATA_W-1:0]           i_gray_data,
  input  logic                        i_cnt_ready,
  output logic                        o_cnt_valid,
  output logic [$clog2(NUM_BINS)-1:0] o_cnt_bin,
  output logic [CNT_W-1:0]            o_cnt_data,
  output logic                        o_cnt_last,
  output logic                        o_oor_pulse,
  output logic                        o_overrun
);
  localparam int unsigned BIN_W = $clog2(NUM_BINS);
  // Offset math is widened so NUM_BINS up to 64 never truncates against a narrow DATA_W
  localparam int unsigned OFF_W = ((DATA_W > 7) ? DATA_W : 7) + 1;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

  typedef enum logic {S_IDLE, S_DUMP} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_gv_d;
  logic [CNT_W-1:0] r_live [NUM_BINS];
  logic [CNT_W-1:0] r_snap [NUM_BINS];
  logic [BIN_W-1:0] r_idx, w_idx_nxt;
  logic             r_valid, r_last, r_oor, r_overrun;
  logic [BIN_W-1:0] r_bin;
  logic [CNT_W-1:0] r_data;
  logic             w_fe, w_in_range, w_snap_ld, w_overrun;
  logic             w_valid_nxt, w_last_nxt;
  logic [CNT_W-1:0] w_data_nxt;
  logic [OFF_W-1:0] w_off;
  logic [BIN_W-1:0] w_hit_bin;

  function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] v);
`ifdef GRAY_HIST_SAT_EN
    return (&v) ? v : v + CNT_W'(1);
`else
    return v + CNT_W'(1);
`endif
  endfunction

  assign w_fe       = r_gv_d & ~i_gray_valid;
  assign w_off      = OFF_W'(i_gray_data) - OFF_W'(BIN_BASE);
  assign w_in_range = (OFF_W'(i_gray_data) >= OFF_W'(BIN_BASE)) && (w_off < OFF_W'(NUM_BINS));
  assign w_hit_bin  = w_off[BIN_W-1:0];

  // Live bank: cleared at every frame end, whether or not the snapshot is taken
  always_ff @(posedge i_clk) begin
    if (i_reset || w_fe) begin
      for (int unsigned i = 0; i < NUM_BINS; i++) r_live[i] <= '0;
    end else if (i_gray_valid && w_in_range) begin
      r_live[w_hit_bin] <= f_inc(r_live[w_hit_bin]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NUM_BINS; i++) r_snap[i] <= '0;
    end else if (w_snap_ld) begin
      r_snap <= r_live;
    end
  end

  // Next state, readout index and next registered output values
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_snap_ld   = 1'b0;
    w_overrun   = 1'b0;
    w_valid_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    w_data_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_fe) begin
          w_snap_ld   = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_DUMP;
        end
      end
      S_DUMP: begin
        w_overrun = w_fe;
        if (i_cnt_ready) begin
          if (r_idx == LAST_BIN) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt = r_idx + BIN_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_valid_nxt = (w_state_nxt == S_DUMP);
    w_last_nxt  = w_valid_nxt && (w_idx_nxt == LAST_BIN);
    if (w_valid_nxt) w_data_nxt = w_snap_ld ? r_live[w_idx_nxt] : r_snap[w_idx_nxt];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_gv_d    <= 1'b0;
      r_valid   <= 1'b0;
      r_bin     <= '0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_oor     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_gv_d    <= i_gray_valid;
      r_valid   <= w_valid_nxt;
      r_bin     <= w_idx_nxt;
      r_data    <= w_data_nxt;
      r_last    <= w_last_nxt;
      r_oor     <= i_gray_valid & ~w_in_range;
      r_overrun <= w_overrun;
    end
  end

  assign o_cnt_valid = r_valid;
  assign o_cnt_bin   = r_bin;
  assign o_cnt_data  = r_data;
  assign o_cnt_last  = r_last;
  assign o_oor_pulse = r_oor;
  assign o_overrun   = r_overrun;
endmodule
